// File: rtl/tf_gen_ctrl_pkg.sv
// Purpose : shared types and default sizing for the twiddle-factor generator sequencer.
// Latency : n/a (definitions only).
// Backpressure : n/a.
package tf_ctrl_pkg;

  // Default sizing of the generator bank.
  localparam int IT_DEPTH  = 3;
  localparam int GROUPS    = 16;
  localparam int MUL_LAT   = 4;
  localparam int D_WIDTH   = 2;  // generator it_depth_cnt port width

  localparam int LAT_CNT_W = $clog2(MUL_LAT + 2);
  localparam int GRP_W     = $clog2(GROUPS);

  // State encoding kept as plain constants so older tools and waveform
  // decoders that expect raw codes keep working.
  typedef logic [2:0] tf_state_e;
  localparam tf_state_e ST_IDLE     = 3'd0;
  localparam tf_state_e ST_LD_CONST = 3'd1;
  localparam tf_state_e ST_LD_BASE  = 3'd2;
  localparam tf_state_e ST_WAIT_REQ = 3'd3;
  localparam tf_state_e ST_READ     = 3'd4;
  localparam tf_state_e ST_WB       = 3'd5;
  localparam tf_state_e ST_FIN      = 3'd6;

endpackage

// File: rtl/tf_gen_ctrl_if.sv
// Purpose : bundle between the NTT stage controller (master) and the sequencer (slave).
// Latency : n/a (wires only).
// Backpressure : ld_valid/ld_ready for table words, tf_req level held until tf_valid.
// Signals : start, ld_valid, tf_req (master->slave); ld_ready, tf_valid, tf_init_const,
//           tf_init_base, tf_ren, tf_wen, tf_depth_cnt, busy, done (slave->master/generator).
interface tf_gen_ctrl_if
  import tf_ctrl_pkg::*;
#(
  parameter int CNT_W = D_WIDTH
);
  logic             start;
  logic             ld_valid;
  logic             ld_ready;
  logic             tf_req;
  logic             tf_valid;
  logic             tf_init_const;
  logic             tf_init_base;
  logic             tf_ren;
  logic             tf_wen;
  logic [CNT_W-1:0] tf_depth_cnt;
  logic             busy;
  logic             done;

  modport master (
    output start, ld_valid, tf_req,
    input  ld_ready, tf_valid, tf_init_const, tf_init_base, tf_ren, tf_wen,
           tf_depth_cnt, busy, done
  );

  modport slave (
    input  start, ld_valid, tf_req,
    output ld_ready, tf_valid, tf_init_const, tf_init_base, tf_ren, tf_wen,
           tf_depth_cnt, busy, done
  );
endinterface

// File: rtl/tf_gen_ctrl_lat_cnt.sv
// Purpose : down-counter timing how long operands stay stable for the Barrett multiplier.
// Latency : count visible the cycle after load/decrement.
// Backpressure : none; saturates at zero.
// Ports : clk, rst (sync, active-high), load + load_val, dec, cnt (current value), zero flag.
module tf_lat_cnt
  import tf_ctrl_pkg::*;
#(
  parameter int W = LAT_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/tf_gen_ctrl.sv
// Purpose : sequences the twiddle-factor generator: constant load, per-depth base load, then request service.
// Latency : all outputs registered; a command appears the cycle after the handshake that caused it.
// Backpressure : stalls in LD_* while ld_valid low; waits in WAIT_REQ for tf_req; start ignored while busy.
// Ports : clk, rst (sync, active-high); bus (slave modport) carrying start/ld_valid/tf_req in and
//         ld_ready, tf_valid, one-hot generator commands, tf_depth_cnt, busy, done out.
module tf_gen_ctrl
  import tf_ctrl_pkg::*;
#(
  parameter int IT_DEPTH = tf_ctrl_pkg::IT_DEPTH,
  parameter int CNT_W    = D_WIDTH,
  parameter int GROUPS   = tf_ctrl_pkg::GROUPS,
  parameter int MUL_LAT  = tf_ctrl_pkg::MUL_LAT
) (
  input  logic          clk,
  input  logic          rst,
  tf_gen_ctrl_if.slave  bus
);
  localparam int LW = $clog2(MUL_LAT + 2);
  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  localparam logic [CNT_W-1:0] DEPTH_LAST = CNT_W'(IT_DEPTH - 1);
  localparam logic [GW-1:0]    GRP_LAST   = GW'(GROUPS - 1);
  localparam logic [LW-1:0]    LAT_LOAD   = LW'(MUL_LAT);

  tf_state_e        state_q, state_d;
  logic [CNT_W-1:0] depth_q, depth_d;
  logic [GW-1:0]    group_q, group_d;

  logic             ld_ready_q, ld_ready_d;
  logic             valid_q, valid_d;
  logic             init_const_q, init_const_d;
  logic             init_base_q, init_base_d;
  logic             ren_q, ren_d;
  logic             wen_q, wen_d;
  logic [CNT_W-1:0] depth_out_q, depth_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             lat_load, lat_dec, lat_zero;
  logic [LW-1:0]    lat_cnt;

  // READ holds for MUL_LAT+1 cycles: loaded with MUL_LAT, leaves READ on zero.
  tf_lat_cnt #(.W(LW)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (LAT_LOAD),
    .dec      (lat_dec),
    .cnt      (lat_cnt),
    .zero     (lat_zero)
  );

  always_comb begin
    state_d      = state_q;
    depth_d      = depth_q;
    group_d      = group_q;
    lat_load     = 1'b0;
    lat_dec      = 1'b0;
    init_const_d = 1'b0;
    init_base_d  = 1'b0;
    valid_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LD_CONST;
          depth_d = '0;
          group_d = '0;
        end
      end
      ST_LD_CONST: begin
        if (bus.ld_valid) begin
          init_const_d = 1'b1;
          state_d      = ST_LD_BASE;
        end
      end
      ST_LD_BASE: begin
        if (bus.ld_valid) begin
          init_base_d = 1'b1;
          if (depth_q == DEPTH_LAST) begin
            depth_d = '0;
            state_d = ST_WAIT_REQ;
          end else begin
            depth_d = depth_q + CNT_W'(1);
          end
        end
      end
      ST_WAIT_REQ: begin
        if (bus.tf_req) begin
          state_d  = ST_READ;
          lat_load = 1'b1;
        end
      end
      ST_READ: begin
        // Counter still at its load value only during the first ren cycle,
        // so the registered valid lands one cycle later.
        valid_d = (lat_cnt == LAT_LOAD);
        if (lat_zero) state_d = ST_WB;
        else          lat_dec = 1'b1;
      end
      ST_WB: begin
        if (group_q == GRP_LAST) begin
          group_d = '0;
          if (depth_q == DEPTH_LAST) begin
            depth_d = '0;
            state_d = ST_FIN;
          end else begin
            depth_d = depth_q + CNT_W'(1);
            state_d = ST_WAIT_REQ;
          end
        end else begin
          group_d = group_q + GW'(1);
          state_d = ST_WAIT_REQ;
        end
      end
      ST_FIN: begin
        depth_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        depth_d = '0;
        group_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    ren_d       = (state_d == ST_READ);
    wen_d       = (state_d == ST_WB);
    ld_ready_d  = (state_d == ST_LD_CONST) || (state_d == ST_LD_BASE);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FIN);
    // An init_base must address the row being written, not the incremented depth.
    depth_out_d = init_base_d ? depth_q : depth_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      depth_q      <= '0;
      group_q      <= '0;
      ld_ready_q   <= 1'b0;
      valid_q      <= 1'b0;
      init_const_q <= 1'b0;
      init_base_q  <= 1'b0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      depth_out_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      depth_q      <= depth_d;
      group_q      <= group_d;
      ld_ready_q   <= ld_ready_d;
      valid_q      <= valid_d;
      init_const_q <= init_const_d;
      init_base_q  <= init_base_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
      depth_out_q  <= depth_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.ld_ready      = ld_ready_q;
  assign bus.tf_valid      = valid_q;
  assign bus.tf_init_const = init_const_q;
  assign bus.tf_init_base  = init_base_q;
  assign bus.tf_ren        = ren_q;
  assign bus.tf_wen        = wen_q;
  assign bus.tf_depth_cnt  = depth_out_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
endmodule

// File: tb/tb_tf_gen_ctrl.sv
// Purpose : self-checking bench for tf_gen_ctrl against a transaction-level reference model.
// Latency : model predicts the registered outputs produced by each clock edge.
// Backpressure : exercises ld_valid gaps, held and sparse tf_req, and start noise while busy.
module tb_tf_gen_ctrl;
  localparam int IT_DEPTH = 3;
  localparam int CNT_W    = 2;
  localparam int GROUPS   = 16;
  localparam int MUL_LAT  = 4;

  typedef struct packed {
    logic             ld_ready;
    logic             tf_valid;
    logic             init_const;
    logic             init_base;
    logic             ren;
    logic             wen;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] depth;
  } ov_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tf_gen_ctrl_if #(.CNT_W(CNT_W)) bus ();

  tf_gen_ctrl #(
    .IT_DEPTH (IT_DEPTH),
    .CNT_W    (CNT_W),
    .GROUPS   (GROUPS),
    .MUL_LAT  (MUL_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a run is "loading" until IT_DEPTH+1 table words are taken,
  // then each accepted request expands into a fixed burst of future outputs.
  ov_t sched[$];
  ov_t exp_v;
  bit  m_active = 0;
  int  m_loads  = 0;
  int  m_served = 0;

  int cnt_ic, cnt_ib, cnt_ren, cnt_valid, cnt_wen, cnt_done;
  logic prev_wen = 1'b0;

  function automatic ov_t vec(bit rdy, bit v, bit ic, bit ib, bit rn, bit wn,
                              bit bsy, bit dn, int d);
    ov_t o;
    o.ld_ready   = rdy;
    o.tf_valid   = v;
    o.init_const = ic;
    o.init_base  = ib;
    o.ren        = rn;
    o.wen        = wn;
    o.busy       = bsy;
    o.done       = dn;
    o.depth      = CNT_W'(d);
    return o;
  endfunction

  task automatic model(input logic r, input logic s, input logic l, input logic q);
    int d;
    if (r) begin
      sched.delete();
      m_active = 0;
      exp_v    = '0;
    end else if (sched.size() > 0) begin
      exp_v = sched.pop_front();
    end else if (!m_active) begin
      if (s) begin
        m_active = 1;
        m_loads  = 0;
        m_served = 0;
        exp_v    = vec(1, 0, 0, 0, 0, 0, 1, 0, 0);
      end else begin
        exp_v = '0;
      end
    end else if (m_loads <= IT_DEPTH) begin
      d = (m_loads == 0) ? 0 : m_loads - 1;
      if (l) begin
        exp_v = vec(m_loads < IT_DEPTH, 0, m_loads == 0, m_loads != 0, 0, 0, 1, 0, d);
        m_loads++;
      end else begin
        exp_v = vec(1, 0, 0, 0, 0, 0, 1, 0, d);
      end
    end else begin
      d = m_served / GROUPS;
      if (q) begin
        exp_v = vec(0, 0, 0, 0, 1, 0, 1, 0, d);
        sched.push_back(vec(0, 1, 0, 0, 1, 0, 1, 0, d));
        for (int i = 0; i < MUL_LAT - 1; i++) sched.push_back(vec(0, 0, 0, 0, 1, 0, 1, 0, d));
        sched.push_back(vec(0, 0, 0, 0, 0, 1, 1, 0, d));
        m_served++;
        if (m_served == IT_DEPTH * GROUPS) begin
          sched.push_back(vec(0, 0, 0, 0, 0, 0, 1, 1, 0));
          sched.push_back('0);
          m_active = 0;
        end else begin
          sched.push_back(vec(0, 0, 0, 0, 0, 0, 1, 0, m_served / GROUPS));
        end
      end else begin
        exp_v = vec(0, 0, 0, 0, 0, 0, 1, 0, d);
      end
    end
  endtask

  task automatic clear_stats();
    cnt_ic = 0; cnt_ib = 0; cnt_ren = 0; cnt_valid = 0; cnt_wen = 0; cnt_done = 0;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic s, input logic l, input logic q);
    ov_t obs;
    rst          = r;
    bus.start    = s;
    bus.ld_valid = l;
    bus.tf_req   = q;
    @(posedge clk);
    model(r, s, l, q);
    #1;
    obs.ld_ready   = bus.ld_ready;
    obs.tf_valid   = bus.tf_valid;
    obs.init_const = bus.tf_init_const;
    obs.init_base  = bus.tf_init_base;
    obs.ren        = bus.tf_ren;
    obs.wen        = bus.tf_wen;
    obs.busy       = bus.busy;
    obs.done       = bus.done;
    obs.depth      = bus.tf_depth_cnt;
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
    vectors++;
    assert (($countones({obs.init_const, obs.init_base, obs.ren, obs.wen}) <= 1) === 1'b1) else begin
      miscompares++;
      $error("FAIL %s_onehot observed=%b expected=one-hot-or-zero",
             tag, {obs.init_const, obs.init_base, obs.ren, obs.wen});
    end
    vectors++;
    assert ((int'(obs.depth) < IT_DEPTH) === 1'b1) else begin
      miscompares++;
      $error("FAIL %s_depth_range observed=%0d expected<%0d", tag, obs.depth, IT_DEPTH);
    end
    if (obs.done === 1'b1) begin
      vectors++;
      assert (prev_wen === 1'b1) else begin
        miscompares++;
        $error("FAIL %s_done_after_wb observed_prev_wen=%b expected=1", tag, prev_wen);
      end
    end
    prev_wen = obs.wen;
    cnt_ic    += int'(obs.init_const);
    cnt_ib    += int'(obs.init_base);
    cnt_ren   += int'(obs.ren);
    cnt_valid += int'(obs.tf_valid);
    cnt_wen   += int'(obs.wen);
    cnt_done  += int'(obs.done);
  endtask

  initial begin
    bit finished;
    bus.start = 1'b0; bus.ld_valid = 1'b0; bus.tf_req = 1'b0;
    clear_stats();

    // Reset state, then idle noise on ld_valid/tf_req must do nothing.
    step("reset", 1, 0, 0, 0);
    step("reset", 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) step("idle_noise", 0, 0, 1, 1);

    // Back-to-back table load.
    clear_stats();
    step("start", 0, 1, 0, 0);
    for (int i = 0; i < IT_DEPTH + 1; i++) step("load", 0, 0, 1, 0);
    chk("load_const_cnt", cnt_ic, 1);
    chk("load_base_cnt", cnt_ib, IT_DEPTH);

    // Single request with ld_valid/start noise around it.
    clear_stats();
    step("req1", 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) step("req1_tail", 0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
    chk("req1_ren_cycles", cnt_ren, MUL_LAT + 1);
    chk("req1_valid_pulses", cnt_valid, 1);
    chk("req1_wen_pulses", cnt_wen, 1);

    // Reset in the second READ cycle aborts the sequence.
    step("req2", 0, 0, 0, 1);
    step("req2_read", 0, 0, 0, 0);
    step("rst_mid_read", 1, 0, 0, 0);
    chk("rst_busy", int'(bus.busy), 0);
    for (int i = 0; i < 3; i++) step("post_rst", 0, 0, 1, 1);

    // Load with a 3-cycle ld_valid gap, start noise, then random gaps.
    clear_stats();
    step("start2", 0, 1, 0, 0);
    step("ld_const", 0, 0, 1, 0);
    step("ld_base0", 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("ld_gap", 0, 1, 0, 0);
    step("ld_base1", 0, 0, 1, 0);
    for (int i = 0; i < 50 && m_loads <= IT_DEPTH; i++)
      step("ld_rand", 0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
    chk("gap_base_cnt", cnt_ib, IT_DEPTH);
    for (int i = 0; i < 4; i++) step("wait_noise", 0, 1, 1, 0);

    // tf_req held high through the whole service phase.
    clear_stats();
    finished = 0;
    for (int i = 0; i < 2000 && !finished; i++) begin
      step("held_req", 0, $urandom_range(0, 1), $urandom_range(0, 1), 1);
      if (bus.busy === 1'b0) finished = 1;
    end
    chk("held_finished", int'(finished), 1);
    chk("held_wen_total", cnt_wen, IT_DEPTH * GROUPS);
    chk("held_ren_total", cnt_ren, IT_DEPTH * GROUPS * (MUL_LAT + 1));
    chk("held_valid_total", cnt_valid, IT_DEPTH * GROUPS);
    chk("held_done_total", cnt_done, 1);

    // Full fresh run with random ld_valid and sparse requests.
    clear_stats();
    step("start3", 0, 1, 0, 0);
    finished = 0;
    for (int i = 0; i < 8000 && !finished; i++) begin
      step("rand_run", 0, $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
      if (bus.busy === 1'b0) finished = 1;
    end
    chk("rand_finished", int'(finished), 1);
    chk("rand_ib_total", cnt_ib, IT_DEPTH);
    chk("rand_wen_total", cnt_wen, IT_DEPTH * GROUPS);
    chk("rand_done_total", cnt_done, 1);
    for (int i = 0; i < 3; i++) step("final_idle", 0, 0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
